dsp_postadd_pipe: RTL and testbench
===================================

Name: dsp_postadd_pipe

Overview:
Parametrised successor to the DSP48A1 X/Z/B/carry multiplexer stage. It selects the X and Z post-adder operands, adds or subtracts them with a selectable carry, and registers P, carry-out and a valid flag. It adds an optional opmode/carry pipeline, signed saturation and a sticky overflow flag. It sits between the multiplier/operand pipeline registers and the P/PCOUT outputs of the slice.

Parameters:
A_WIDTH, 18, width of a_in
B_WIDTH, 18, width of b_in, bcin, b_opnd, b2
D_WIDTH, 18, width of d_in; must be >= P_WIDTH-A_WIDTH-B_WIDTH
P_WIDTH, 48, width of the post-adder, P, C and PCIN; must be > A_WIDTH+B_WIDTH
B_INPUT, "DIRECT", b2 source: "DIRECT"=b_in, "CASCADE"=bcin, anything else=0
CARRYINSEL, "OPMODE5", carry source: "OPMODE5"=opmode[5], "CARRYIN"=carryin, anything else=0
OPMODEREG, 1, 0/1: number of register stages on opmode and in_valid
CARRYINREG, 1, 0/1: number of register stages on the selected carry
SATURATE, 0, 1 clamps P to the signed range on overflow

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ce  in  1  clock enable for every internal register
in_valid  in  1  operation valid, aligned with opmode
opmode  in  8  [1:0] X select, [3:2] Z select, [5] carry, [7] subtract; [4] and [6] ignored
carryin  in  1  external carry
m_in  in  A_WIDTH+B_WIDTH  multiplier product, signed
d_in  in  D_WIDTH  D operand
a_in  in  A_WIDTH  A operand
b_opnd  in  B_WIDTH  pipelined B operand for D:A:B
b_in  in  B_WIDTH  direct B
bcin  in  B_WIDTH  cascade B
c_in  in  P_WIDTH  C operand
pcin  in  P_WIDTH  P cascade in
b2  out  B_WIDTH  combinational B selection
p  out  P_WIDTH  result
pcout  out  P_WIDTH  equals p
carryout  out  1  bit P_WIDTH of the unsigned sum (borrow when subtracting)
out_valid  out  1  p holds a new result
overflow  out  1  sticky signed overflow
clr_ovf  in  1  synchronous clear of overflow

Behaviour:
- Reset (rst_n low, async, any time including mid-accumulation): p, carryout, out_valid, overflow, opmode stage, valid stage and carry stage all go to 0 immediately. First capture occurs on the first rising edge after release.
- ce=0: all registers hold, including out_valid and overflow; clr_ovf is ignored.
- Control stage:
  - When OPMODEREG=1, opmode and in_valid are registered at edge t and used in cycle t+1; when 0 they are used directly.
  - Carry (CIN) is selected from raw opmode[5] or carryin per CARRYINSEL, then delayed by CARRYINREG cycles.
- Operand inputs (m_in, d_in, a_in, b_opnd, c_in, pcin) are sampled in the cycle the delayed opmode is applied. Upstream pipeline registers provide the alignment.
- X mux:
  - 00 = 0
  - 01 = m_in sign-extended to P_WIDTH
  - 10 = p
  - 11 = {d_in[P_WIDTH-A_WIDTH-B_WIDTH-1:0], a_in, b_opnd}
- Z mux: 00 = 0, 01 = pcin, 10 = p, 11 = c_in.
- Arithmetic:
  - opmode[7]=0: R = Z + X + CIN.
  - opmode[7]=1: R = Z - (X + CIN).
  - R is computed at full precision in P_WIDTH+2 signed bits.
  - carryout is bit P_WIDTH of the (P_WIDTH+1)-bit unsigned zero-extended computation of the same expression.
- Overflow:
  - ovf = R lies outside [-2^(P_WIDTH-1), 2^(P_WIDTH-1)-1].
  - SATURATE=1 with ovf: P gets max positive if R > 0, else min negative.
  - SATURATE=0: P gets R[P_WIDTH-1:0] (wraps).
- P register captures on every ce edge, valid or not. Feedback selections (X=10, Z=10) use the registered p.
- out_valid is the delayed in_valid registered alongside P. Latency from in_valid to out_valid is OPMODEREG+1 cycles.
- overflow:
  - Set on an edge where ce=1, the delayed valid=1 and ovf=1.
  - Cleared by clr_ovf=1 with ce=1.
  - If set and clear occur on the same edge, set wins.
- b2 is purely combinational from b_in/bcin per B_INPUT and is independent of clk and reset.
- Target implementation size: 120-400 lines.

Test Plan:
1. Reset mid-operation: accumulate to p=12, drop rst_n between edges -> p=0, out_valid=0, overflow=0 without waiting for a clock edge.
2. Multiply-add, defaults: opmode=8'h0D, m_in=-2, c_in=10, in_valid for 1 cycle -> 2 cycles later p=8, out_valid=1 for one cycle, carryout=1.
3. Accumulate: opmode=8'h09, m_in=3, in_valid for 4 consecutive cycles starting from p=0 -> p=3,6,9,12; ce=0 for 2 cycles mid-run -> p and out_valid hold.
4. Subtract with carry: opmode=8'hAD, c_in=100, m_in=30 -> p=69. Same case with CARRYINSEL="CARRYIN", carryin=0 -> p=70.
5. Saturation: SATURATE=1, opmode=8'h0D, c_in=48'h7FFF_FFFF_FFFF, m_in=1 -> p=48'h7FFF_FFFF_FFFF, overflow=1 and sticky. Next, clr_ovf together with a new overflowing beat -> overflow stays 1; clr_ovf alone -> 0.
6. Concatenation and cascade: B_INPUT="CASCADE", OPMODEREG=0, opmode=8'h03, d_in=18'h3_0ABC, a_in=18'h1_2345, b_opnd=18'h0_0001, bcin=18'h2_AAAA -> b2=18'h2_AAAA immediately, and one cycle later p={12'hABC, 18'h1_2345, 18'h0_0001}.

Source files
------------

// File: rtl/dsp_postadd_pipe.sv
// dsp_postadd_pipe: X/Z operand select, post-adder with selectable carry, optional control pipeline, saturation and sticky overflow
module dsp_postadd_pipe #(
  parameter int    A_WIDTH    = 18,
  parameter int    B_WIDTH    = 18,
  parameter int    D_WIDTH    = 18,
  parameter int    P_WIDTH    = 48,
  parameter string B_INPUT    = "DIRECT",
  parameter string CARRYINSEL = "OPMODE5",
  parameter int    OPMODEREG  = 1,
  parameter int    CARRYINREG = 1,
  parameter int    SATURATE   = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ce,
  input  logic                       in_valid,
  input  logic [7:0]                 opmode,
  input  logic                       carryin,
  input  logic [A_WIDTH+B_WIDTH-1:0] m_in,
  input  logic [D_WIDTH-1:0]         d_in,
  input  logic [A_WIDTH-1:0]         a_in,
  input  logic [B_WIDTH-1:0]         b_opnd,
  input  logic [B_WIDTH-1:0]         b_in,
  input  logic [B_WIDTH-1:0]         bcin,
  input  logic [P_WIDTH-1:0]         c_in,
  input  logic [P_WIDTH-1:0]         pcin,
  output logic [B_WIDTH-1:0]         b2,
  output logic [P_WIDTH-1:0]         p,
  output logic [P_WIDTH-1:0]         pcout,
  output logic                       carryout,
  output logic                       out_valid,
  output logic                       overflow,
  input  logic                       clr_ovf
);
  localparam int MW = A_WIDTH + B_WIDTH;
  localparam int CW = P_WIDTH - MW;
  localparam logic [P_WIDTH-1:0] P_MAX = {1'b0, {(P_WIDTH-1){1'b1}}};
  localparam logic [P_WIDTH-1:0] P_MIN = {1'b1, {(P_WIDTH-1){1'b0}}};
  logic [7:0]         op_q, op;
  logic               vld_q, vld, cin_q, cin_d, cin;
  logic [P_WIDTH-1:0] p_q, p_d, x, z;
  logic               co_q, out_valid_q, ovf_q, ovf_d, ovf;
  logic [P_WIDTH+1:0] r;
  logic [P_WIDTH:0]   u;
  logic [D_WIDTH:0]   d_ext;
  logic               unused_bits;
  assign b2    = (B_INPUT == "DIRECT") ? b_in : (B_INPUT == "CASCADE") ? bcin : '0;
  assign op    = (OPMODEREG != 0) ? op_q : opmode;
  assign vld   = (OPMODEREG != 0) ? vld_q : in_valid;
  assign cin_d = (CARRYINSEL == "OPMODE5") ? opmode[5] : (CARRYINSEL == "CARRYIN") ? carryin : 1'b0;
  assign cin   = (CARRYINREG != 0) ? cin_q : cin_d;
  assign d_ext = {1'b0, d_in};
  always_comb begin
    x = (op[1:0] == 2'b00) ? '0 :
        (op[1:0] == 2'b01) ? {{CW{m_in[MW-1]}}, m_in} :
        (op[1:0] == 2'b10) ? p_q : {d_in[CW-1:0], a_in, b_opnd};
    z = (op[3:2] == 2'b00) ? '0 :
        (op[3:2] == 2'b01) ? pcin :
        (op[3:2] == 2'b10) ? p_q : c_in;
    // signed result keeps two guard bits; unsigned copy only feeds carryout
    r = op[7] ? {{2{z[P_WIDTH-1]}}, z} - ({{2{x[P_WIDTH-1]}}, x} + (P_WIDTH+2)'(cin))
              : {{2{z[P_WIDTH-1]}}, z} + {{2{x[P_WIDTH-1]}}, x} + (P_WIDTH+2)'(cin);
    u = op[7] ? {1'b0, z} - ({1'b0, x} + (P_WIDTH+1)'(cin))
              : {1'b0, z} + {1'b0, x} + (P_WIDTH+1)'(cin);
    ovf   = !((r[P_WIDTH+1:P_WIDTH-1] == 3'b000) || (r[P_WIDTH+1:P_WIDTH-1] == 3'b111));
    p_d   = (SATURATE != 0 && ovf) ? (r[P_WIDTH+1] ? P_MIN : P_MAX) : r[P_WIDTH-1:0];
    ovf_d = (vld && ovf) || (ovf_q && !clr_ovf);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      vld_q       <= 1'b0;
      cin_q       <= 1'b0;
      p_q         <= '0;
      co_q        <= 1'b0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (ce) begin
      op_q        <= opmode;
      vld_q       <= in_valid;
      cin_q       <= cin_d;
      p_q         <= p_d;
      co_q        <= u[P_WIDTH];
      out_valid_q <= vld;
      ovf_q       <= ovf_d;
    end
  end
  assign p           = p_q;
  assign pcout       = p_q;
  assign carryout    = co_q;
  assign out_valid   = out_valid_q;
  assign overflow    = ovf_q;
  assign unused_bits = ^{op[6], op[4], opmode[6], opmode[4], d_ext[D_WIDTH:CW], carryin, u[P_WIDTH-1:0]};
endmodule

// File: tb/tb_dsp_postadd_pipe.sv
// tb_dsp_postadd_pipe: default and alternate-configuration instances against an arithmetic reference model
module tb_dsp_postadd_pipe;
  localparam longint PMAX = 64'sh0000_7FFF_FFFF_FFFF;
  localparam longint PMIN = -PMAX - 1;
  logic        clk = 0, rst_n = 0, ce = 0, in_valid = 0, carryin = 0, clr_ovf = 0;
  logic [7:0]  opmode = '0;
  logic [35:0] m_in = '0;
  logic [17:0] d_in = '0, a_in = '0, b_opnd = '0, b_in = '0, bcin = '0;
  logic [47:0] c_in = '0, pcin = '0;
  logic [17:0] b2_0, b2_1;
  logic [47:0] p_0, p_1, pc_0, pc_1;
  logic        co_0, co_1, ov_0, ov_1, of_0, of_1;
  int n_tests = 0, n_fail = 0;
  bit          opreg[2]  = '{1'b1, 1'b0};
  bit          cinreg[2] = '{1'b1, 1'b0};
  bit          sat[2]    = '{1'b0, 1'b1};
  logic [7:0]  mo[2];
  bit          mv[2], mc[2], mco[2], mout[2], mov[2];
  logic [47:0] mp[2];
  always #5 clk = ~clk;
  dsp_postadd_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .opmode(opmode), .carryin(carryin),
    .m_in(m_in), .d_in(d_in), .a_in(a_in), .b_opnd(b_opnd), .b_in(b_in), .bcin(bcin),
    .c_in(c_in), .pcin(pcin), .b2(b2_0), .p(p_0), .pcout(pc_0), .carryout(co_0),
    .out_valid(ov_0), .overflow(of_0), .clr_ovf(clr_ovf));
  dsp_postadd_pipe #(.B_INPUT("CASCADE"), .CARRYINSEL("CARRYIN"), .OPMODEREG(0), .CARRYINREG(0), .SATURATE(1)) u_alt (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .opmode(opmode), .carryin(carryin),
    .m_in(m_in), .d_in(d_in), .a_in(a_in), .b_opnd(b_opnd), .b_in(b_in), .bcin(bcin),
    .c_in(c_in), .pcin(pcin), .b2(b2_1), .p(p_1), .pcout(pc_1), .carryout(co_1),
    .out_valid(ov_1), .overflow(of_1), .clr_ovf(clr_ovf));
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      mo[c] = '0; mv[c] = 0; mc[c] = 0; mp[c] = '0; mco[c] = 0; mout[c] = 0; mov[c] = 0;
    end
  endtask
  task automatic model_step();
    logic [7:0] op; bit v, craw, cin, ovf; logic [47:0] xv, zv; longint r, u;
    for (int c = 0; c < 2; c++) begin
      if (ce) begin
        op   = opreg[c] ? mo[c] : opmode;
        v    = opreg[c] ? mv[c] : in_valid;
        craw = (c == 0) ? opmode[5] : carryin;
        cin  = cinreg[c] ? mc[c] : craw;
        case (op[1:0])
          2'd0: xv = '0;
          2'd1: xv = 48'($signed(m_in));
          2'd2: xv = mp[c];
          default: xv = {d_in[11:0], a_in, b_opnd};
        endcase
        case (op[3:2])
          2'd0: zv = '0;
          2'd1: zv = pcin;
          2'd2: zv = mp[c];
          default: zv = c_in;
        endcase
        r = op[7] ? longint'($signed(zv)) - (longint'($signed(xv)) + cin) : longint'($signed(zv)) + longint'($signed(xv)) + cin;
        u = op[7] ? longint'(zv) - (longint'(xv) + cin) : longint'(zv) + longint'(xv) + cin;
        ovf = (r > PMAX) || (r < PMIN);
        mov[c] = (v && ovf) || (mov[c] && !clr_ovf);
        mp[c]  = (sat[c] && ovf) ? ((r > 0) ? 48'(PMAX) : 48'(PMIN)) : 48'(r);
        mco[c] = u[48];
        mout[c] = v;
        mo[c] = opmode; mv[c] = in_valid; mc[c] = craw;
      end
    end
  endtask
  task automatic compare_all();
    check("p0", p_0, mp[0]);      check("pcout0", pc_0, mp[0]);  check("co0", co_0, mco[0]);
    check("ov0", ov_0, mout[0]);  check("ovf0", of_0, mov[0]);   check("b2_0", b2_0, b_in);
    check("p1", p_1, mp[1]);      check("pcout1", pc_1, mp[1]);  check("co1", co_1, mco[1]);
    check("ov1", ov_1, mout[1]);  check("ovf1", of_1, mov[1]);   check("b2_1", b2_1, bcin);
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask
  task automatic mid_reset();
    rst_n = 0;
    #1;
    model_reset();
    check("rst_p0", p_0, 0); check("rst_ov0", ov_0, 0); check("rst_ovf0", of_0, 0);
    check("rst_p1", p_1, 0); check("rst_ovf1", of_1, 0);
    compare_all();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask
  function automatic logic [47:0] r48();
    return 48'({$urandom(), $urandom()});
  endfunction
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_p0", p_0, 0); check("init_co0", co_0, 0); check("init_ov0", ov_0, 0); check("init_ovf0", of_0, 0);
    compare_all();
    rst_n = 1; ce = 1;
    // accumulate 3 four times with a two-cycle ce stall
    opmode = 8'h09; m_in = 36'd3; in_valid = 1;
    tick(); tick();
    check("acc_p3", p_0, 48'd3);
    ce = 0; tick(); tick();
    check("hold_p", p_0, 48'd3); check("hold_ov", ov_0, 1);
    ce = 1; tick(); tick();
    opmode = 8'h08; in_valid = 0; tick();
    check("acc_p12", p_0, 48'd12);
    mid_reset();
    // multiply-add
    opmode = 8'h0D; m_in = 36'hF_FFFF_FFFE; c_in = 48'd10; in_valid = 1; tick();
    opmode = 8'h00; in_valid = 0; tick();
    check("madd_p", p_0, 48'd8); check("madd_co", co_0, 1); check("madd_ov", ov_0, 1);
    tick();
    check("madd_ov_drop", ov_0, 0);
    // subtract with carry
    opmode = 8'hAD; c_in = 48'd100; m_in = 36'd30; carryin = 0; in_valid = 1; tick();
    check("sub_alt_p", p_1, 48'd70);
    opmode = 8'h00; in_valid = 0; tick();
    check("sub_p", p_0, 48'd69);
    // saturation and sticky overflow on the alternate instance
    mid_reset();
    opmode = 8'h0D; c_in = 48'h7FFF_FFFF_FFFF; m_in = 36'd1; in_valid = 1; tick();
    check("sat_p", p_1, 48'h7FFF_FFFF_FFFF); check("sat_ovf", of_1, 1);
    opmode = 8'h00; in_valid = 0; tick();
    check("sticky", of_1, 1);
    opmode = 8'h0D; in_valid = 1; clr_ovf = 1; tick();
    check("set_wins", of_1, 1);
    opmode = 8'h00; in_valid = 0; tick();
    check("clr_ovf", of_1, 0);
    clr_ovf = 0;
    // concatenation and cascade B
    opmode = 8'h03; d_in = 18'h3_0ABC; a_in = 18'h1_2345; b_opnd = 18'h0_0001; bcin = 18'h2_AAAA; b_in = 18'h0_1234; in_valid = 1;
    #1;
    check("b2_casc", b2_1, 18'h2_AAAA); check("b2_dir", b2_0, 18'h0_1234);
    tick();
    check("concat_p", p_1, {12'hABC, 18'h1_2345, 18'h0_0001});
    for (int i = 0; i < 600; i++) begin
      opmode = 8'($urandom); carryin = 1'($urandom); in_valid = 1'($urandom);
      ce = ($urandom_range(0, 7) != 0); clr_ovf = ($urandom_range(0, 7) == 0);
      m_in = 36'({$urandom(), $urandom()});
      d_in = 18'($urandom); a_in = 18'($urandom); b_opnd = 18'($urandom); b_in = 18'($urandom); bcin = 18'($urandom);
      c_in = ($urandom_range(0, 2) == 0) ? r48() : 48'($urandom_range(0, 1000));
      pcin = ($urandom_range(0, 2) == 0) ? r48() : 48'($urandom_range(0, 1000));
      if (i % 150 == 149) mid_reset();
      else tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
